pix_tx: RTL and testbench

- Image readback transmitter: reverse direction of the pixel receive path.
- On request, reads a stored W x H frame of 12-bit pixels from SPRAM and serialises it as a framed byte stream toward uart_tx.
- Stream format matches the receive framing: header, two bytes per pixel, one XOR check byte per row.
- Sits between the SPRAM read port (time-shared with ram/VGA via i_grant) and the uart_tx input mux in top.

---
 rtl/image_pkg.sv | 31 +++
 rtl/pix_tx_if.sv | 23 ++
 rtl/tx_byte_hs.sv | 30 +++
 rtl/pix_tx.sv | 147 ++++++++++++++
 tb/tb_pix_tx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// image_pkg: shared image geometry, pixel width, framing bytes and pix_tx state encoding.
// S_CRC exists only when PIX_TX_FRAME_SUM_EN is defined.
package image_pkg;
   localparam int IMG_W = 50;
   localparam int IMG_H = 40;
   localparam int PIX_W = 12;
   localparam int ADDR_W_DEF = 15;
   localparam logic [7:0] HDR0_DEF = 8'hAA;
   localparam logic [7:0] HDR1_DEF = 8'h55;
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      S_HDR0  = 4'd1,
      S_HDR1  = 4'd2,
      RD_REQ  = 4'd3,
      RD_WAIT = 4'd4,
      S_HI    = 4'd5,
      S_LO    = 4'd6,
      S_CHK   = 4'd7,
`ifdef PIX_TX_FRAME_SUM_EN
      S_CRC   = 4'd8,
`endif
      FIN     = 4'd9
   } state_t;
   function automatic logic is_tx(state_t s);
`ifdef PIX_TX_FRAME_SUM_EN
      return s inside {S_HDR0, S_HDR1, S_HI, S_LO, S_CHK, S_CRC};
`else
      return s inside {S_HDR0, S_HDR1, S_HI, S_LO, S_CHK};
`endif
   endfunction
endpackage

// File: rtl/pix_tx_if.sv
// pix_tx_if: start/abort control, SPRAM read port and uart_tx byte handshake of pix_tx.
interface pix_tx_if #(parameter int ADDR_W = 15) ();
   import image_pkg::*;
   logic              i_start;
   logic              i_abort;
   logic              i_grant;
   logic              o_spram_ce;
   logic [ADDR_W-1:0] o_spram_addr;
   logic [PIX_W-1:0]  i_spram_dout;
   logic [7:0]        o_tx_data;
   logic              o_tx_valid;
   logic              i_tx_done;
   logic              o_busy;
   logic              o_done;
   modport master (
      input  i_start, i_abort, i_grant, i_spram_dout, i_tx_done,
      output o_spram_ce, o_spram_addr, o_tx_data, o_tx_valid, o_busy, o_done
   );
   modport slave (
      output i_start, i_abort, i_grant, i_spram_dout, i_tx_done,
      input  o_spram_ce, o_spram_addr, o_tx_data, o_tx_valid, o_busy, o_done
   );
endinterface

// File: rtl/tx_byte_hs.sv
// tx_byte_hs: one-cycle valid pulse per loaded byte, then busy until uart_tx reports done.
module tx_byte_hs (
   input  logic       i_clk_sys,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   input  logic       i_tx_done,
   output logic [7:0] o_tx_data,
   output logic       o_tx_valid,
   output logic       o_busy
);
   logic       valid_q;
   logic       wait_q;
   logic [7:0] data_q;
   // wait_q only arms after the valid cycle, so a done coincident with valid is ignored
   always_ff @(posedge i_clk_sys or posedge i_rst)
      if (i_rst) begin
         valid_q <= 1'b0;
         wait_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= i_load & ~i_clr;
         wait_q  <= ~i_clr & (valid_q | (wait_q & ~i_tx_done));
         if (i_load) data_q <= i_byte;
      end
   assign o_tx_data  = data_q;
   assign o_tx_valid = valid_q;
   assign o_busy     = valid_q | wait_q;
endmodule

// File: rtl/pix_tx.sv
// pix_tx: reads a W x H frame from SPRAM and streams header, pixel byte pairs and row XOR bytes to uart_tx.
// Defining PIX_TX_FRAME_SUM_EN appends a wrapping 8-bit sum of all pixel bytes after the last row.
module pix_tx
   import image_pkg::*;
#(
   parameter int         W      = IMG_W,
   parameter int         H      = IMG_H,
   parameter int         ADDR_W = ADDR_W_DEF,
   parameter logic [7:0] HDR0   = HDR0_DEF,
   parameter logic [7:0] HDR1   = HDR1_DEF
) (
   input logic      i_clk_sys,
   input logic      i_rst,
   pix_tx_if.master bus
);
   localparam int CW = $clog2(W + 1);
   localparam int RW = $clog2(H + 1);
`ifdef PIX_TX_FRAME_SUM_EN
   localparam state_t LAST = S_CRC;
`else
   localparam state_t LAST = FIN;
`endif
   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        byte_s;
   logic              load;
   logic              hs_busy;
   logic              last_col;
   logic              last_row;
`ifdef PIX_TX_FRAME_SUM_EN
   logic [7:0]        sum_q, sum_d;
`endif
   assign last_col = col_q == CW'(W - 1);
   assign last_row = row_q == RW'(H - 1);
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      idx_d   = idx_q;
      pix_d   = pix_q;
      chk_d   = chk_q;
`ifdef PIX_TX_FRAME_SUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         IDLE: if (bus.i_start) begin
            state_d = S_HDR0;
`ifdef PIX_TX_FRAME_SUM_EN
            sum_d   = '0;
`endif
         end
         S_HDR0:  if (!hs_busy) state_d = S_HDR1;
         S_HDR1:  if (!hs_busy) state_d = RD_REQ;
         RD_REQ:  if (bus.i_grant) state_d = RD_WAIT;
         RD_WAIT: begin
            pix_d   = bus.i_spram_dout;
            state_d = S_HI;
         end
         S_HI:    if (!hs_busy) state_d = S_LO;
         S_LO:    if (!hs_busy) begin
            state_d = last_col ? S_CHK : RD_REQ;
            col_d   = last_col ? col_q : col_q + 1'b1;
            idx_d   = last_col ? idx_q : idx_q + 1'b1;
         end
         S_CHK:   if (!hs_busy) begin
            chk_d   = '0;
            col_d   = '0;
            state_d = last_row ? LAST : RD_REQ;
            row_d   = last_row ? row_q : row_q + 1'b1;
            idx_d   = last_row ? idx_q : idx_q + 1'b1;
         end
`ifdef PIX_TX_FRAME_SUM_EN
         S_CRC:   if (!hs_busy) state_d = FIN;
`endif
         FIN: begin
            state_d = IDLE;
            row_d   = '0;
            idx_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      if (bus.i_abort) begin
         state_d = IDLE;
         col_d   = '0;
         row_d   = '0;
         idx_d   = '0;
         chk_d   = '0;
      end
      // the byte is chosen by the state being entered, so valid rises in that state's first cycle
      byte_s = (state_d == S_HDR0) ? HDR0 :
               (state_d == S_HDR1) ? HDR1 :
               (state_d == S_HI)   ? {4'h0, pix_d[11:8]} :
               (state_d == S_LO)   ? pix_d[7:0] :
`ifdef PIX_TX_FRAME_SUM_EN
               (state_d == S_CRC)  ? sum_q :
`endif
               chk_q;
      load = is_tx(state_d) && (state_d != state_q);
      if (load && (state_d == S_HI || state_d == S_LO)) begin
         chk_d = chk_q ^ byte_s;
`ifdef PIX_TX_FRAME_SUM_EN
         sum_d = sum_q + byte_s;
`endif
      end
   end
   always_ff @(posedge i_clk_sys or posedge i_rst)
      if (i_rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         pix_q   <= '0;
         chk_q   <= '0;
`ifdef PIX_TX_FRAME_SUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         chk_q   <= chk_d;
`ifdef PIX_TX_FRAME_SUM_EN
         sum_q   <= sum_d;
`endif
      end
   tx_byte_hs u_hs (
      .i_clk_sys  (i_clk_sys),
      .i_rst      (i_rst),
      .i_clr      (bus.i_abort),
      .i_load     (load),
      .i_byte     (byte_s),
      .i_tx_done  (bus.i_tx_done),
      .o_tx_data  (bus.o_tx_data),
      .o_tx_valid (bus.o_tx_valid),
      .o_busy     (hs_busy)
   );
   assign bus.o_spram_ce   = (state_q == RD_REQ) & bus.i_grant & ~bus.i_abort;
   assign bus.o_spram_addr = idx_q;
   assign bus.o_busy       = state_q != IDLE;
   assign bus.o_done       = (state_q == FIN) & ~bus.i_abort;
endmodule

// File: tb/tb_pix_tx.sv
// tb_pix_tx: directed and randomized frames on a 2x2 image checked against a byte-stream model.
// Expects the trailing frame-sum byte when PIX_TX_FRAME_SUM_EN is defined.
module tb_pix_tx;
   import image_pkg::*;
   localparam int W = 2, H = 2, AW = 15, N = W * H;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0, n_fail = 0;
   int cnt_valid = 0, cnt_done = 0;
   int resp_delay = 10, grant_mode = 1;
   int gb, cb, db, vb;
   logic [PIX_W-1:0] mem [N];
   logic [7:0] got_q[$], exp_q[$];
   logic [AW-1:0] ce_q[$];
   logic [7:0] gold [12] = '{8'hAA, 8'h55, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h94, 8'h04, 8'h56, 8'h07, 8'h89, 8'hDC};
   pix_tx_if #(.ADDR_W(AW)) bus ();
   pix_tx #(.W(W), .H(H), .ADDR_W(AW)) dut (.i_clk_sys(clk), .i_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // uart_tx stand-in: capture each byte, report done after resp_delay cycles (0 = random)
   initial begin
      bus.i_tx_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.o_tx_valid) begin
            got_q.push_back(bus.o_tx_data);
            repeat (resp_delay == 0 ? int'($urandom_range(1, 12)) : resp_delay) @(posedge clk);
            #1 bus.i_tx_done = 1'b1;
            @(posedge clk); #1 bus.i_tx_done = 1'b0;
         end
      end
   end
   initial begin
      bus.i_spram_dout = '0;
      forever begin
         @(negedge clk);
         if (bus.o_spram_ce) begin
            ce_q.push_back(bus.o_spram_addr);
            @(posedge clk); #1 bus.i_spram_dout = mem[ce_q[$]];
         end
      end
   end
   initial forever begin
      bus.i_grant = (grant_mode == 2) ? 1'($urandom_range(0, 1)) : grant_mode[0];
      @(posedge clk); #1;
   end
   initial forever begin
      @(negedge clk);
      if (bus.o_tx_valid) cnt_valid++;
      if (bus.o_done) cnt_done++;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic build_exp();
      logic [7:0] c, s, hi, lo;
      exp_q = {};
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      s = '0;
      for (int r = 0; r < H; r++) begin
         c = '0;
         for (int x = 0; x < W; x++) begin
            hi = 8'(mem[r * W + x] >> 8);
            lo = 8'(mem[r * W + x]);
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            c = c ^ hi ^ lo;
            s = s + hi + lo;
         end
         exp_q.push_back(c);
      end
`ifdef PIX_TX_FRAME_SUM_EN
      exp_q.push_back(s);
`endif
   endtask
   task automatic start_frame();
      build_exp();
      gb = got_q.size();
      cb = ce_q.size();
      db = cnt_done;
      vb = cnt_valid;
      bus.i_start = 1'b1;
      cyc(1);
      bus.i_start = 1'b0;
      chk("busy_on_accept", bus.o_busy, 1);
      chk("first_valid", bus.o_tx_valid, 1);
   endtask
   task automatic wait_valid(input int n);
      int t = 0;
      while (cnt_valid - vb < n && t < 2000) begin
         cyc(1);
         t++;
      end
      chk("wait_valid", 32'(cnt_valid - vb >= n), 1);
   endtask
   task automatic finish_frame(input string tag);
      int t = 0;
      while (cnt_done == db && t < 8000) begin
         cyc(1);
         t++;
      end
      cyc(5);
      chk({tag, "_done_cnt"}, cnt_done - db, 1);
      chk({tag, "_busy_end"}, bus.o_busy, 0);
      chk({tag, "_nbytes"}, got_q.size() - gb, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk({tag, "_byte"}, (gb + i < got_q.size()) ? 32'(got_q[gb + i]) : 'x, exp_q[i]);
      chk({tag, "_nreads"}, ce_q.size() - cb, N);
      for (int i = 0; i < N; i++)
         chk({tag, "_addr"}, (cb + i < ce_q.size()) ? 32'(ce_q[cb + i]) : 'x, i);
   endtask
   initial begin
      int v0, d0;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      mem = '{12'h123, 12'hABC, 12'h456, 12'h789};
      cyc(3);
      chk("rst_ce", bus.o_spram_ce, 0);
      chk("rst_valid", bus.o_tx_valid, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_addr", bus.o_spram_addr, 0);
      chk("rst_data", bus.o_tx_data, 0);
      @(negedge clk) rst = 1'b0;
      cyc(3);
      start_frame();
      finish_frame("fixed");
      for (int i = 0; i < 12; i++)
         chk("gold_byte", (gb + i < got_q.size()) ? 32'(got_q[gb + i]) : 'x, gold[i]);
`ifdef PIX_TX_FRAME_SUM_EN
      chk("gold_sum", (gb + 12 < got_q.size()) ? 32'(got_q[gb + 12]) : 'x, 8'hD4);
`endif
      start_frame();
      cyc(40);
      bus.i_start = 1'b1;
      cyc(1);
      bus.i_start = 1'b0;
      finish_frame("restart");
      v0 = cnt_valid;
      bus.i_start = 1'b1;
      bus.i_abort = 1'b1;
      cyc(1);
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      chk("start_abort_busy", bus.o_busy, 0);
      cyc(10);
      chk("start_abort_quiet", cnt_valid - v0, 0);
      grant_mode = 0;
      start_frame();
      wait_valid(2);
      cyc(80);
      chk("nogrant_ce", ce_q.size() - cb, 0);
      chk("nogrant_valid", cnt_valid - vb, 2);
      chk("nogrant_busy", bus.o_busy, 1);
      grant_mode = 1;
      finish_frame("grant");
      start_frame();
      wait_valid(5);
      cyc(3);
      bus.i_abort = 1'b1;
      cyc(1);
      bus.i_abort = 1'b0;
      chk("abort_busy", bus.o_busy, 0);
      chk("abort_valid", bus.o_tx_valid, 0);
      chk("abort_addr", bus.o_spram_addr, 0);
      v0 = cnt_valid;
      d0 = cnt_done;
      cyc(30);
      chk("abort_no_done", cnt_done - d0, 0);
      chk("abort_quiet", cnt_valid - v0, 0);
      start_frame();
      finish_frame("after_abort");
      start_frame();
      wait_valid(4);
      #3 rst = 1'b1;
      #1;
      chk("arst_ce", bus.o_spram_ce, 0);
      chk("arst_valid", bus.o_tx_valid, 0);
      chk("arst_busy", bus.o_busy, 0);
      chk("arst_done", bus.o_done, 0);
      chk("arst_addr", bus.o_spram_addr, 0);
      chk("arst_data", bus.o_tx_data, 0);
      v0 = cnt_valid;
      cyc(2);
      @(negedge clk) rst = 1'b0;
      cyc(30);
      chk("arst_idle_busy", bus.o_busy, 0);
      chk("arst_quiet", cnt_valid - v0, 0);
      grant_mode = 2;
      resp_delay = 0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
         start_frame();
         finish_frame("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
